// File: rtl/demux_collect_16_pkg.sv
// Shared constants and FSM encoding for the 1-to-16 word collector.
// Combinational definitions only; no latency, no flow control.
// Backpressure: not applicable.
package demux_collect_16_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int NUM_WORDS_DEF  = 16;
    localparam int IDX_WIDTH      = 5;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/demux_collect_16_onehot_dec_16.sv
// Slot write-enable decoder: index -> one-hot, gated by the accept strobe.
// Latency: purely combinational.
// Backpressure: none; indices at or above NUM_WORDS enable nothing.
module onehot_dec_16
    import demux_collect_16_pkg::*;
#(
    parameter int NUM_WORDS = NUM_WORDS_DEF,
    parameter int IDX_W     = IDX_WIDTH
) (
    input  logic [IDX_W-1:0]     idx,
    input  logic                 strobe,
    output logic [NUM_WORDS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (strobe && (idx == IDX_W'(k))) begin
                onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_collect_16.sv
// Collects NUM_WORDS serial words into slots 0..N-1, then presents them as one frame.
// Latency: frame valid the cycle after the last word is accepted; no bypass on release.
// Backpressure: in_ready drops for the whole HOLD phase until the frame handshake.
module demux_collect_16
    import demux_collect_16_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_WORDS  = NUM_WORDS_DEF,
    parameter int IDX_W      = IDX_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_WORDS*DATA_WIDTH-1:0] out_bus,
    output logic [IDX_W-1:0]                wr_index
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_e               state;
    logic                 accept;
    logic                 release_frame;
    logic [NUM_WORDS-1:0] wr_en;

    // Both flags decode registered state only, so neither port sees a comb path.
    assign in_ready  = (state == ST_FILL);
    assign out_valid = (state == ST_HOLD);

    // clear drops any word or frame handshake offered in the same cycle.
    assign accept        = in_valid && in_ready && !clear;
    assign release_frame = out_ready && out_valid && !clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FILL;
            wr_index <= '0;
        end else if (clear) begin
            state    <= ST_FILL;
            wr_index <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        if (wr_index == LAST_IDX) begin
                            state    <= ST_HOLD;
                            wr_index <= '0;
                        end else begin
                            wr_index <= wr_index + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (release_frame) begin
                        state <= ST_FILL;
                    end
                end
                default: begin
                    state    <= ST_FILL;
                    wr_index <= '0;
                end
            endcase
        end
    end

    onehot_dec_16 #(
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W)
    ) u_dec (
        .idx    (wr_index),
        .strobe (accept),
        .onehot (wr_en)
    );

    // Slots keep the previous frame until individually overwritten by the next one.
    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_slot
        logic [DATA_WIDTH-1:0] slot_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                slot_q <= '0;
            end else if (wr_en[k]) begin
                slot_q <= in_data;
            end
        end

        assign out_bus[k*DATA_WIDTH +: DATA_WIDTH] = slot_q;
    end

endmodule

// File: tb/tb_demux_collect_16.sv
// Bench for demux_collect_16: directed scenarios plus a randomized frame scoreboard.
// A negedge monitor models accepted words and checks every released frame.
module tb_demux_collect_16;

    localparam int DW = 16;
    localparam int NW = 16;
    localparam int IW = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           clear = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [DW-1:0]  in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [NW*DW-1:0] out_bus;
    logic [IW-1:0]  wr_index;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    demux_collect_16 #(
        .DATA_WIDTH (DW),
        .NUM_WORDS  (NW),
        .IDX_W      (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bus   (out_bus),
        .wr_index  (wr_index)
    );

    // Scoreboard model, evaluated at negedge for the coming posedge.
    logic [NW*DW-1:0] exp_q[$];
    logic [NW*DW-1:0] cur_frame = '0;
    logic [NW*DW-1:0] exp_frame;
    logic             mon_en = 1'b0;
    logic             model_hold = 1'b0;
    int               model_cnt = 0;
    int               released = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            vectors++;
            if (out_valid !== model_hold) begin
                miscompares++;
                $display("FAIL mon_out_valid t=%0t got=%b exp=%b", $time, out_valid, model_hold);
            end
            vectors++;
            if (in_ready !== !model_hold) begin
                miscompares++;
                $display("FAIL mon_in_ready t=%0t got=%b exp=%b", $time, in_ready, !model_hold);
            end
            vectors++;
            if (wr_index !== IW'(model_cnt)) begin
                miscompares++;
                $display("FAIL mon_wr_index t=%0t got=%0d exp=%0d", $time, wr_index, model_cnt);
            end
            if (rst || clear) begin
                if (model_hold && exp_q.size() > 0) void'(exp_q.pop_front());
                model_hold = 1'b0;
                model_cnt  = 0;
            end else if (model_hold) begin
                if (out_ready) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL frame_underflow t=%0t got=frame exp=none", $time);
                    end else begin
                        exp_frame = exp_q.pop_front();
                        if (out_bus !== exp_frame) begin
                            miscompares++;
                            $display("FAIL frame_data t=%0t got=%h exp=%h", $time, out_bus, exp_frame);
                        end
                    end
                    model_hold = 1'b0;
                    released++;
                end
            end else if (in_valid) begin
                cur_frame[model_cnt*DW +: DW] = in_data;
                if (model_cnt == NW - 1) begin
                    exp_q.push_back(cur_frame);
                    model_hold = 1'b1;
                    model_cnt  = 0;
                end else begin
                    model_cnt++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        mon_en = 1'b1;
        rst = 1'b0;
        vectors++;
        if (wr_index !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_bus !== '0) begin
            miscompares++;
            $display("FAIL reset_initial got idx=%0d ov=%b ir=%b bus=%h exp idx=0 ov=0 ir=1 bus=0",
                     wr_index, out_valid, in_ready, out_bus);
        end
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(16'h0100 + i);
            step();
        end
        in_valid = 1'b0;
        vectors++;
        if (wr_index !== IW'(7)) begin
            miscompares++;
            $display("FAIL reset_prefill_idx got=%0d exp=7", wr_index);
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        vectors++;
        if (wr_index !== '0) begin miscompares++; $display("FAIL reset_idx got=%0d exp=0", wr_index); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        vectors++;
        if (out_bus !== '0) begin miscompares++; $display("FAIL reset_out_bus got=%h exp=0", out_bus); end
    endtask

    task automatic test_full_frame();
        out_ready = 1'b1;
        for (int i = 0; i < NW; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i + 1);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL full_early_valid word=%0d got=%b exp=0", i, out_valid);
            end
            step();
        end
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL full_out_valid got=%b exp=1", out_valid); end
        vectors++;
        if (out_bus[0 +: DW] !== 16'h0001) begin
            miscompares++;
            $display("FAIL full_slot0 got=%h exp=0001", out_bus[0 +: DW]);
        end
        vectors++;
        if (out_bus[15*DW +: DW] !== 16'h0010) begin
            miscompares++;
            $display("FAIL full_slot15 got=%h exp=0010", out_bus[15*DW +: DW]);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL full_valid_len got=%b exp=0", out_valid); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL full_in_ready got=%b exp=1", in_ready); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [NW*DW-1:0] snap;
        out_ready = 1'b0;
        for (int i = 0; i < NW; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(16'h0200 + i);
            step();
        end
        snap = out_bus;
        in_data = 16'hBEEF;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_flags cyc=%0d got ir=%b ov=%b exp ir=0 ov=1", c, in_ready, out_valid);
            end
            vectors++;
            if (out_bus !== snap) begin
                miscompares++;
                $display("FAIL bp_stable cyc=%0d got=%h exp=%h", c, out_bus, snap);
            end
            if (c < 4) step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release got=%b exp=0", out_valid); end
    endtask

    task automatic test_input_gaps();
        in_valid = 1'b1; in_data = 16'hA5A5; step();
        in_valid = 1'b0; in_data = 16'hFFFF; step();
        in_valid = 1'b1; in_data = 16'h5A5A; step();
        in_valid = 1'b0; step();
        vectors++;
        if (out_bus[0 +: DW] !== 16'hA5A5) begin
            miscompares++;
            $display("FAIL gaps_slot0 got=%h exp=a5a5", out_bus[0 +: DW]);
        end
        vectors++;
        if (out_bus[DW +: DW] !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL gaps_slot1 got=%h exp=5a5a", out_bus[DW +: DW]);
        end
        vectors++;
        if (wr_index !== IW'(2)) begin miscompares++; $display("FAIL gaps_idx got=%0d exp=2", wr_index); end
    endtask

    task automatic test_clear();
        clear = 1'b1; step(); clear = 1'b0;
        vectors++;
        if (wr_index !== '0) begin miscompares++; $display("FAIL clear_first_idx got=%0d exp=0", wr_index); end
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(16'h0300 + i);
            step();
        end
        clear = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD;
        step();
        clear = 1'b0; in_valid = 1'b0;
        vectors++;
        if (wr_index !== '0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_state got idx=%0d ov=%b exp idx=0 ov=0", wr_index, out_valid);
        end
        vectors++;
        if (out_bus[9*DW +: DW] !== 16'h0209) begin
            miscompares++;
            $display("FAIL clear_dropped_word got=%h exp=0209", out_bus[9*DW +: DW]);
        end
        vectors++;
        if (out_bus[0 +: DW] !== 16'h0300 || out_bus[8*DW +: DW] !== 16'h0308) begin
            miscompares++;
            $display("FAIL clear_kept_slots got s0=%h s8=%h exp s0=0300 s8=0308",
                     out_bus[0 +: DW], out_bus[8*DW +: DW]);
        end
    endtask

    task automatic test_random();
        int target;
        int cyc;
        target = released + 200;
        cyc = 0;
        while (released < target && cyc < 40000) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = DW'($urandom);
            out_ready = ($urandom % 3) == 0;
            clear     = ($urandom % 250) == 0;
            step();
            cyc++;
        end
        vectors++;
        if (released < target) begin
            miscompares++;
            $display("FAIL random_timeout got=%0d frames exp=%0d", released - (target - 200), 200);
        end
        in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        vectors++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL random_drain got pending=%0d ov=%b exp pending=0 ov=0", exp_q.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_input_gaps();
        test_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
